// File: rtl/mig_ui_arbiter.sv
// Round-robin N-channel front end for the MIG native UI: one command in flight,
// read data steered back to its issuing channel through an in-order tag FIFO.
`timescale 1ns/1ps
module mig_ui_arbiter #(
    parameter int NCH       = 2,
    parameter int DW        = 128,
    parameter int AW        = 30,
    parameter int TAG_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        ch_req,
    input  logic [NCH-1:0]        ch_we,
    input  logic [NCH*AW-1:0]     ch_addr,
    input  logic [NCH*DW-1:0]     ch_wdata,
    input  logic [NCH*DW/8-1:0]   ch_wmask,
    output logic [NCH-1:0]        ch_gnt,
    output logic [NCH-1:0]        ch_rd_valid,
    output logic [DW-1:0]         ch_rd_data,
    output logic [AW-1:0]         app_addr,
    output logic [2:0]            app_cmd,
    output logic                  app_en,
    output logic [DW-1:0]         app_wdf_data,
    output logic [DW/8-1:0]       app_wdf_mask,
    output logic                  app_wdf_wren,
    output logic                  app_wdf_end,
    input  logic                  app_rdy,
    input  logic                  app_wdf_rdy,
    input  logic [DW-1:0]         app_rd_data,
    input  logic                  app_rd_data_valid,
    output logic                  app_ref_req,
    output logic                  app_zq_req,
    input  logic                  init_calib_complete,
    output logic                  busy,
    output logic                  err_underflow
);

    localparam int TW = (NCH > 2) ? $clog2(NCH) : 1;
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int MW = DW / 8;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          state;
    logic [TW-1:0]   ptr;
    logic [TW-1:0]   win;
    logic [TW-1:0]   cand;
    logic [TW-1:0]   issue_ch;
    logic            found;
    logic [NCH-1:0]  elig;
    int unsigned     idx;

    logic [TW-1:0]   tag_mem [TAG_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == (PW+1)'(TAG_DEPTH));
    assign empty = (count == '0);
    assign push  = app_en & app_rdy & app_cmd[0];
    assign pop   = app_rd_data_valid & ~empty;
    // A read may only be granted if its tag is guaranteed a FIFO slot.
    assign elig  = ch_req & (ch_we | {NCH{~full}});

    assign app_wdf_end = app_wdf_wren;
    assign app_ref_req = 1'b0;
    assign app_zq_req  = 1'b0;
    assign busy        = (state != IDLE) || !empty;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx  = (32'(ptr) + k) % NCH;
            cand = TW'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            issue_ch     <= '0;
            ch_gnt       <= '0;
            app_addr     <= '0;
            app_cmd      <= '0;
            app_en       <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            app_wdf_wren <= 1'b0;
        end else begin
            ch_gnt <= '0;
            case (state)
                IDLE: begin
                    if (init_calib_complete && found) begin
                        ch_gnt[win]  <= 1'b1;
                        app_addr     <= ch_addr[win*AW +: AW];
                        app_wdf_data <= ch_wdata[win*DW +: DW];
                        app_wdf_mask <= ch_wmask[win*MW +: MW];
                        app_cmd      <= ch_we[win] ? 3'b000 : 3'b001;
                        app_en       <= 1'b1;
                        app_wdf_wren <= ch_we[win];
                        issue_ch     <= win;
                        ptr          <= (win == TW'(NCH-1)) ? '0 : win + 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A low app_en / app_wdf_wren doubles as the "done" flag for that half.
                    if (app_rdy)
                        app_en <= 1'b0;
                    if (app_wdf_rdy)
                        app_wdf_wren <= 1'b0;
                    if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= issue_ch;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            ch_rd_valid   <= '0;
            ch_rd_data    <= '0;
            err_underflow <= 1'b0;
        end else begin
            ch_rd_valid <= '0;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                    <= rd_ptr + 1'b1;
                ch_rd_valid[tag_mem[rd_ptr]] <= 1'b1;
                ch_rd_data                <= app_rd_data;
            end
            if (app_rd_data_valid && empty)
                err_underflow <= 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mig_ui_arbiter.sv
// Directed bench for mig_ui_arbiter (NCH=2, TAG_DEPTH=2): grant order, write
// handshake stretching, in-order read return, tag-full blocking, underflow, reset.
`timescale 1ns/1ps
module tb_mig_ui_arbiter;

    localparam int NCH = 2;
    localparam int DW  = 128;
    localparam int AW  = 30;
    localparam int MW  = DW / 8;

    localparam logic [DW-1:0] D0 = 128'h0D0D_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [DW-1:0] D1 = 128'h0D1D_0001_7777_8888_9999_AAAA_BBBB_CCCC;
    localparam logic [DW-1:0] D2 = 128'h0D2D_0002_DDDD_EEEE_FFFF_0123_4567_89AB;
    localparam logic [DW-1:0] DX = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       ch_req;
    logic [NCH-1:0]       ch_we;
    logic [NCH*AW-1:0]    ch_addr;
    logic [NCH*DW-1:0]    ch_wdata;
    logic [NCH*MW-1:0]    ch_wmask;
    logic [NCH-1:0]       ch_gnt;
    logic [NCH-1:0]       ch_rd_valid;
    logic [DW-1:0]        ch_rd_data;
    logic [AW-1:0]        app_addr;
    logic [2:0]           app_cmd;
    logic                 app_en;
    logic [DW-1:0]        app_wdf_data;
    logic [MW-1:0]        app_wdf_mask;
    logic                 app_wdf_wren;
    logic                 app_wdf_end;
    logic                 app_rdy;
    logic                 app_wdf_rdy;
    logic [DW-1:0]        app_rd_data;
    logic                 app_rd_data_valid;
    logic                 app_ref_req;
    logic                 app_zq_req;
    logic                 init_calib_complete;
    logic                 busy;
    logic                 err_underflow;

    int n_checks = 0;
    int n_fail   = 0;

    mig_ui_arbiter #(
        .NCH(NCH),
        .DW(DW),
        .AW(AW),
        .TAG_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ch_req(ch_req),
        .ch_we(ch_we),
        .ch_addr(ch_addr),
        .ch_wdata(ch_wdata),
        .ch_wmask(ch_wmask),
        .ch_gnt(ch_gnt),
        .ch_rd_valid(ch_rd_valid),
        .ch_rd_data(ch_rd_data),
        .app_addr(app_addr),
        .app_cmd(app_cmd),
        .app_en(app_en),
        .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy),
        .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data),
        .app_rd_data_valid(app_rd_data_valid),
        .app_ref_req(app_ref_req),
        .app_zq_req(app_zq_req),
        .init_calib_complete(init_calib_complete),
        .busy(busy),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [MW-1:0] mask);
        ch_we[i]            = we;
        ch_addr[i*AW +: AW] = addr;
        ch_wdata[i*DW +: DW] = data;
        ch_wmask[i*MW +: MW] = mask;
    endtask

    initial begin
        rst                 = 1'b1;
        ch_req              = '0;
        ch_we               = '0;
        ch_addr             = '0;
        ch_wdata            = '0;
        ch_wmask            = '0;
        app_rdy             = 1'b0;
        app_wdf_rdy         = 1'b0;
        app_rd_data         = '0;
        app_rd_data_valid   = 1'b0;
        init_calib_complete = 1'b0;

        tick();
        tick();
        check("rst_gnt",   ch_gnt, 0);
        check("rst_en",    app_en, 0);
        check("rst_wren",  app_wdf_wren, 0);
        check("rst_rdv",   ch_rd_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_err",   err_underflow, 0);
        check("rst_ref",   app_ref_req, 0);
        check("rst_zq",    app_zq_req, 0);
        rst = 1'b0;

        // Calibration gating, then round-robin alternation with both writing.
        set_ch(0, 1'b1, 30'h10, {16{8'h11}}, '0);
        set_ch(1, 1'b1, 30'h20, {16{8'h22}}, '0);
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b1;
        ch_req      = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nocal_gnt", ch_gnt, 0);
            check("nocal_en",  app_en, 0);
        end
        init_calib_complete = 1'b1;
        tick();
        check("rr0_gnt",  ch_gnt, 2'b01);
        check("rr0_en",   app_en, 1);
        check("rr0_wren", app_wdf_wren, 1);
        check("rr0_addr", app_addr, 30'h10);
        tick();
        check("rr0_done_gnt", ch_gnt, 0);
        check("rr0_done_en",  app_en, 0);
        check("rr0_done_busy", busy, 0);
        tick();
        check("rr1_gnt",  ch_gnt, 2'b10);
        check("rr1_addr", app_addr, 30'h20);
        tick();
        check("rr1_done_gnt", ch_gnt, 0);
        tick();
        check("rr2_gnt", ch_gnt, 2'b01);
        ch_req = 2'b00;
        tick();
        check("rr2_idle_busy", busy, 0);

        // Write whose data phase is held off for three cycles.
        set_ch(0, 1'b1, 30'h100, {16{8'hA5}}, '0);
        app_rdy     = 1'b1;
        app_wdf_rdy = 1'b0;
        ch_req      = 2'b01;
        tick();
        check("wr_gnt",   ch_gnt, 2'b01);
        check("wr_addr",  app_addr, 30'h100);
        check("wr_data",  app_wdf_data, {16{8'hA5}});
        check("wr_mask",  app_wdf_mask, 0);
        check("wr_cmd",   app_cmd, 3'b000);
        check("wr_en",    app_en, 1);
        check("wr_wren1", app_wdf_wren, 1);
        check("wr_end",   app_wdf_end, 1);
        ch_req = 2'b00;
        tick();
        check("wr_en_drop", app_en, 0);
        check("wr_wren2",   app_wdf_wren, 1);
        check("wr_busy",    busy, 1);
        tick();
        check("wr_wren3", app_wdf_wren, 1);
        tick();
        check("wr_wren4", app_wdf_wren, 1);
        app_wdf_rdy = 1'b1;
        tick();
        check("wr_wren_drop", app_wdf_wren, 0);
        check("wr_idle_busy", busy, 0);

        // Two reads fill the tag FIFO: ch1 (pointer is at 1) then ch0.
        set_ch(1, 1'b0, 30'h200, '0, '0);
        set_ch(0, 1'b0, 30'h300, '0, '0);
        ch_req = 2'b11;
        tick();
        check("rd1_gnt",  ch_gnt, 2'b10);
        check("rd1_cmd",  app_cmd, 3'b001);
        check("rd1_addr", app_addr, 30'h200);
        check("rd1_wren", app_wdf_wren, 0);
        ch_req = 2'b01;
        tick();
        check("rd1_done_gnt", ch_gnt, 0);
        check("rd1_done_en",  app_en, 0);
        tick();
        check("rd2_gnt",  ch_gnt, 2'b01);
        check("rd2_addr", app_addr, 30'h300);
        ch_req = 2'b00;
        tick();
        check("rd2_busy", busy, 1);

        // Tag FIFO full: a ch0 read must wait while a ch1 write proceeds.
        set_ch(0, 1'b0, 30'h400, '0, '0);
        ch_req = 2'b01;
        tick();
        check("full_gnt_a", ch_gnt, 0);
        tick();
        check("full_gnt_b", ch_gnt, 0);
        check("full_en",    app_en, 0);
        set_ch(1, 1'b1, 30'h500, {8{16'h5A5A}}, 16'h000F);
        ch_req = 2'b11;
        tick();
        check("full_wr_gnt",  ch_gnt, 2'b10);
        check("full_wr_cmd",  app_cmd, 3'b000);
        check("full_wr_addr", app_addr, 30'h500);
        check("full_wr_mask", app_wdf_mask, 16'h000F);
        ch_req = 2'b01;
        tick();
        check("full_wr_done_gnt", ch_gnt, 0);
        tick();
        check("full_still_blk", ch_gnt, 0);
        app_rd_data       = D0;
        app_rd_data_valid = 1'b1;
        tick();
        check("ret0_valid", ch_rd_valid, 2'b10);
        check("ret0_data",  ch_rd_data, D0);
        check("ret0_gnt",   ch_gnt, 0);
        app_rd_data_valid = 1'b0;
        tick();
        check("rd3_gnt",     ch_gnt, 2'b01);
        check("rd3_addr",    app_addr, 30'h400);
        check("ret_gap",     ch_rd_valid, 0);
        check("ret_hold",    ch_rd_data, D0);
        // Return beat lands in the same cycle the third read is accepted.
        ch_req            = 2'b00;
        app_rd_data       = D1;
        app_rd_data_valid = 1'b1;
        tick();
        check("ret1_valid", ch_rd_valid, 2'b01);
        check("ret1_data",  ch_rd_data, D1);
        app_rd_data = D2;
        tick();
        check("ret2_valid", ch_rd_valid, 2'b01);
        check("ret2_data",  ch_rd_data, D2);
        app_rd_data_valid = 1'b0;
        tick();
        check("ret_end_valid", ch_rd_valid, 0);
        check("ret_end_busy",  busy, 0);
        check("ret_end_err",   err_underflow, 0);

        // Read data with nothing outstanding.
        app_rd_data       = DX;
        app_rd_data_valid = 1'b1;
        tick();
        check("uf_err",   err_underflow, 1);
        check("uf_valid", ch_rd_valid, 0);
        check("uf_data",  ch_rd_data, D2);
        app_rd_data_valid = 1'b0;
        tick();
        tick();
        check("uf_sticky", err_underflow, 1);
        check("uf_busy",   busy, 0);

        // Asynchronous reset while a command is stalled in ISSUE.
        set_ch(0, 1'b1, 30'h600, {16{8'h66}}, '0);
        app_rdy     = 1'b0;
        app_wdf_rdy = 1'b0;
        ch_req      = 2'b01;
        tick();
        check("ar_gnt", ch_gnt, 2'b01);
        ch_req = 2'b00;
        tick();
        check("ar_en_held", app_en, 1);
        check("ar_busy",    busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_en",   app_en, 0);
        check("ar_wren", app_wdf_wren, 0);
        check("ar_addr", app_addr, 0);
        check("ar_busy0", busy, 0);
        check("ar_err",  err_underflow, 0);
        tick();
        rst     = 1'b0;
        app_rdy = 1'b1;
        tick();
        check("post_rst_gnt", ch_gnt, 0);
        check("post_rst_en",  app_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
